// File: rtl/lsu_split.sv
// lsu_split: load/store unit between the EX/MEM stage and a dcache/bus port.
//
// It accepts one access at a time from the pipeline. A misaligned access is
// either split into two aligned word beats (MISALIGN_SPLIT=1) or answered
// with misaligned_error and no bus traffic (MISALIGN_SPLIT=0). Each beat
// waits at most TIMEOUT_CYCLES cycles for mem_rvalid. A timeout or mem_err
// is reported as access_fault.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   in_valid/in_ready pipeline handshake; in_ready=1 only while idle
//   addr, wdata       byte address and LSB-justified store data
//   mem_op            access size / signedness
//   mem_read/write    direction; exactly one must be set
//   resp_valid        one-cycle completion pulse
//   rdata             extended load data (0 for stores, faults, misaligned)
//   misaligned_error  misaligned access rejected (MISALIGN_SPLIT=0 only)
//   access_fault      bus error or response timeout
//   mem_req/mem_gnt   request handshake
//   mem_addr          word-aligned beat address
//   mem_we            write request
//   mem_byte_en       byte lanes of the beat
//   mem_wdata         lane-aligned store data
//   mem_rvalid        response strobe for loads and stores
//   mem_rdata         raw read word
//   mem_err           bus error, qualified by mem_rvalid

package lsu_split_pkg;
    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_HALF   = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_BYTE_U = 3'd3,
        MEM_HALF_U = 3'd4
    } mem_op_e;
endpackage

module lsu_split
    import lsu_split_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  mem_op_e         mem_op,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            resp_valid,
    output logic [XLEN-1:0] rdata,
    output logic            misaligned_error,
    output logic            access_fault,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_byte_en,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Byte-lane mask of the access across two consecutive words.
    function automatic logic [7:0] lane_be(input mem_op_e op, input logic [1:0] off);
        logic [3:0] base;
        case (op)
            MEM_BYTE, MEM_BYTE_U: base = 4'b0001;
            MEM_HALF, MEM_HALF_U: base = 4'b0011;
            default:              base = 4'b1111;
        endcase
        return {4'b0000, base} << off;
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        case (op)
            MEM_BYTE, MEM_BYTE_U: return 1'b0;
            MEM_HALF, MEM_HALF_U: return off[0];
            default:              return (off != 2'b00);
        endcase
    endfunction

    // Sign/zero extension of the byte-shifted load word.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] r, input mem_op_e op);
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [XLEN-1:0] res;
        b = signed'(r[7:0]);
        h = signed'(r[15:0]);
        case (op)
            MEM_BYTE:   res = b;
            MEM_BYTE_U: res = signed'({{(XLEN-8){1'b0}}, r[7:0]});
            MEM_HALF:   res = h;
            MEM_HALF_U: res = signed'({{(XLEN-16){1'b0}}, r[15:0]});
            default:    res = signed'(r);
        endcase
        return res;
    endfunction

    state_e             state_q;
    state_e             state_nx;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    wdata_q;
    mem_op_e            op_q;
    logic               we_q;
    logic [XLEN-1:0]    lo_q;
    logic [XLEN-1:0]    hi_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    rdata_q;
    logic               mis_q;
    logic               fault_q;

    logic               accept;
    logic [1:0]         off;
    logic [7:0]         be8;
    logic               split;
    logic [2*XLEN-1:0]  wd64;
    logic               beat1;
    logic               in_wait;
    logic               timeout_hit;
    logic               fin_fault;
    logic               fin_mis;
    logic [XLEN-1:0]    lo_nx;
    logic [XLEN-1:0]    hi_nx;
    logic [XLEN-1:0]    ld_word;
    logic [XLEN-1:0]    ld_val;

    assign accept      = (state_q == IDLE) && in_valid && (mem_read ^ mem_write);
    assign off         = addr_q[1:0];
    assign be8         = lane_be(op_q, off);
    assign split       = |be8[7:4];
    assign wd64        = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    assign beat1       = (state_q == REQ1) || (state_q == WAIT1);
    assign in_wait     = (state_q == WAIT0) || (state_q == WAIT1);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // The word arriving this cycle is folded in so the result is ready on
    // the same edge that enters DONE.
    always_comb begin
        lo_nx = lo_q;
        hi_nx = hi_q;
        if (state_q == WAIT0 && mem_rvalid) lo_nx = mem_rdata;
        if (state_q == WAIT1 && mem_rvalid) hi_nx = mem_rdata;
        ld_word = XLEN'({hi_nx, lo_nx} >> {off, 3'b000});
        ld_val  = load_ext(ld_word, op_q);
    end

    always_comb begin
        state_nx  = state_q;
        fin_fault = 1'b0;
        fin_mis   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (MISALIGN_SPLIT == 0 && is_misaligned(mem_op, addr[1:0])) begin
                        state_nx = DONE;
                        fin_mis  = 1'b1;
                    end else begin
                        state_nx = REQ0;
                    end
                end
            end
            REQ0: if (mem_gnt) state_nx = WAIT0;
            REQ1: if (mem_gnt) state_nx = WAIT1;
            WAIT0, WAIT1: begin
                // A response in the final timeout cycle still counts.
                if (mem_rvalid) begin
                    if (mem_err) begin
                        state_nx  = DONE;
                        fin_fault = 1'b1;
                    end else if (state_q == WAIT0 && split) begin
                        state_nx = REQ1;
                    end else begin
                        state_nx = DONE;
                    end
                end else if (timeout_hit) begin
                    state_nx  = DONE;
                    fin_fault = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control and status state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            if (in_wait && !mem_rvalid) cnt_q <= cnt_q + CNT_W'(1);
            else                        cnt_q <= '0;
            if (state_nx == DONE) begin
                mis_q   <= fin_mis;
                fault_q <= fin_fault;
                rdata_q <= (we_q || fin_mis || fin_fault) ? '0 : ld_val;
            end
        end
    end

    // Access and response data
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= mem_op;
            we_q    <= mem_write;
        end
        if (state_q == WAIT0 && mem_rvalid) lo_q <= mem_rdata;
        if (state_q == WAIT1 && mem_rvalid) hi_q <= mem_rdata;
    end

    assign in_ready         = (state_q == IDLE);
    assign resp_valid       = (state_q == DONE);
    assign rdata            = rdata_q;
    assign misaligned_error = mis_q;
    assign access_fault     = fault_q;
    assign mem_req          = (state_q == REQ0) || (state_q == REQ1);
    assign mem_we           = we_q;
    assign mem_addr         = {addr_q[XLEN-1:2], 2'b00} + (beat1 ? XLEN'(4) : XLEN'(0));
    assign mem_byte_en      = beat1 ? be8[7:4] : be8[3:0];
    assign mem_wdata        = beat1 ? wd64[2*XLEN-1:XLEN] : wd64[XLEN-1:0];

endmodule

// File: tb/tb_lsu_split.sv
// Directed testbench for lsu_split: a split-enabled instance for the bus
// scenarios and a MISALIGN_SPLIT=0 instance for the misaligned-error path.
module tb_lsu_split;
    import lsu_split_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, mem_read, mem_write;
    logic [31:0] addr, wdata;
    mem_op_e     mem_op;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    logic        in_ready, resp_valid, misaligned_error, access_fault;
    logic        mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_byte_en;

    logic        in_valid_b;
    logic        gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_in_b;
    logic        in_ready_b, resp_valid_b, mis_b, fault_b, req_b, we_b;
    logic [31:0] rdata_b, maddr_b, mwdata_b;
    logic [3:0]  be_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_split #(.XLEN(32), .MISALIGN_SPLIT(1), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .wdata(wdata), .mem_op(mem_op), .mem_read(mem_read),
        .mem_write(mem_write), .resp_valid(resp_valid), .rdata(rdata),
        .misaligned_error(misaligned_error), .access_fault(access_fault),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    lsu_split #(.XLEN(32), .MISALIGN_SPLIT(0), .TIMEOUT_CYCLES(64)) dut_ns (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .addr(addr), .wdata(wdata), .mem_op(mem_op), .mem_read(mem_read),
        .mem_write(mem_write), .resp_valid(resp_valid_b), .rdata(rdata_b),
        .misaligned_error(mis_b), .access_fault(fault_b),
        .mem_req(req_b), .mem_gnt(gnt_b), .mem_addr(maddr_b), .mem_we(we_b),
        .mem_byte_en(be_b), .mem_wdata(mwdata_b), .mem_rvalid(rvalid_b),
        .mem_rdata(rdata_in_b), .mem_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic rd, input logic wr, input mem_op_e op,
                          input logic [31:0] a, input logic [31:0] wd);
        chk("acc_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_op = op; addr = a; wdata = wd;
        step();
        in_valid = 1'b0;
    endtask

    // Serves one beat: gnt in the first REQ cycle, response one cycle later.
    task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                        input logic ewe, input logic [31:0] ewd, input logic chk_wd,
                        input logic [31:0] rd, input logic err);
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, ea);
        chk({tag, "_be"}, {28'b0, mem_byte_en}, {28'b0, ebe});
        chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, ewe});
        if (chk_wd) chk({tag, "_wdata"}, mem_wdata, ewd);
        chk({tag, "_busy"}, {30'b0, in_ready, resp_valid}, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk({tag, "_wait_noreq"}, {31'b0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rd; mem_err = err;
        step();
        mem_rvalid = 1'b0; mem_err = 1'b0;
    endtask

    task automatic done_chk(input string tag, input logic [31:0] erd, input logic efault);
        chk({tag, "_resp"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_rdata"}, rdata, erd);
        chk({tag, "_fault"}, {31'b0, access_fault}, {31'b0, efault});
        chk({tag, "_mis"}, {31'b0, misaligned_error}, 32'd0);
        chk({tag, "_noreq"}, {31'b0, mem_req}, 32'd0);
        step();
        chk({tag, "_pulse"}, {30'b0, resp_valid, in_ready}, 32'd1);
        chk({tag, "_hold"}, rdata, erd);
    endtask

    initial begin
        int n;
        reset = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; mem_op = MEM_WORD;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        gnt_b = 1'b0; rvalid_b = 1'b0; err_b = 1'b0; rdata_in_b = '0;
        step();
        step();
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_ctl", {28'b0, mem_req, resp_valid, misaligned_error, access_fault}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_b", {27'b0, in_ready_b, req_b, resp_valid_b, mis_b, fault_b}, 32'h10);
        reset = 1'b1;
        step();

        // Aligned word load, 4-cycle latency
        accept(1'b1, 1'b0, MEM_WORD, 32'h100, 32'h0);
        beat("lw", 32'h100, 4'b1111, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        done_chk("lw", 32'hDEADBEEF, 1'b0);

        // Halfword across a word boundary, signed and unsigned
        accept(1'b1, 1'b0, MEM_HALF, 32'h103, 32'h0);
        beat("lh0", 32'h100, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h11223344, 1'b0);
        beat("lh1", 32'h104, 4'b0001, 1'b0, 32'h0, 1'b0, 32'hAABBCCDD, 1'b0);
        done_chk("lh", 32'hFFFFDD11, 1'b0);
        accept(1'b1, 1'b0, MEM_HALF_U, 32'h103, 32'h0);
        beat("lhu0", 32'h100, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h11223344, 1'b0);
        beat("lhu1", 32'h104, 4'b0001, 1'b0, 32'h0, 1'b0, 32'hAABBCCDD, 1'b0);
        done_chk("lhu", 32'h0000DD11, 1'b0);

        // Split store: rdata must be 0 whatever the bus returns
        accept(1'b0, 1'b1, MEM_WORD, 32'h102, 32'hCAFEBABE);
        beat("sw0", 32'h100, 4'b1100, 1'b1, 32'hBABE0000, 1'b1, 32'h12345678, 1'b0);
        beat("sw1", 32'h104, 4'b0011, 1'b1, 32'h0000CAFE, 1'b1, 32'h12345678, 1'b0);
        done_chk("sw", 32'h0, 1'b0);

        // Byte loads and a halfword that fits in one beat
        accept(1'b1, 1'b0, MEM_BYTE, 32'h102, 32'h0);
        beat("lb", 32'h100, 4'b0100, 1'b0, 32'h0, 1'b0, 32'h44801234, 1'b0);
        done_chk("lb", 32'hFFFFFF80, 1'b0);
        accept(1'b1, 1'b0, MEM_BYTE_U, 32'h103, 32'h0);
        beat("lbu", 32'h100, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h9A000000, 1'b0);
        done_chk("lbu", 32'h0000009A, 1'b0);
        accept(1'b1, 1'b0, MEM_HALF, 32'h102, 32'h0);
        beat("lh2", 32'h100, 4'b1100, 1'b0, 32'h0, 1'b0, 32'hBEEF0000, 1'b0);
        done_chk("lh2", 32'hFFFFBEEF, 1'b0);

        // Beat1 address wraps to 0
        accept(1'b1, 1'b0, MEM_HALF, 32'hFFFFFFFF, 32'h0);
        beat("wrap0", 32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h7F000000, 1'b0);
        beat("wrap1", 32'h00000000, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h00000080, 1'b0);
        done_chk("wrap", 32'hFFFF807F, 1'b0);

        // Bus error on beat0 of a split access skips beat1
        accept(1'b1, 1'b0, MEM_WORD, 32'h101, 32'h0);
        beat("err0", 32'h100, 4'b1110, 1'b0, 32'h0, 1'b0, 32'h55555555, 1'b1);
        done_chk("err", 32'h0, 1'b1);

        // Timeout: no response at all
        accept(1'b1, 1'b0, MEM_WORD, 32'h200, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        n = 0;
        while (!resp_valid && n < 200) begin
            step();
            n++;
        end
        chk("to_cycles", n, 32'd64);
        done_chk("to", 32'h0, 1'b1);

        // Response in the last timeout cycle wins
        accept(1'b1, 1'b0, MEM_WORD, 32'h300, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 63; i++) step();
        chk("to_last_noresp", {31'b0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        step();
        mem_rvalid = 1'b0;
        done_chk("to_last", 32'h55AA55AA, 1'b0);

        // Both or neither direction set: ignored
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 32'h100; mem_op = MEM_WORD;
        step();
        chk("both_ign", {30'b0, in_ready, mem_req}, 32'd2);
        mem_read = 1'b0; mem_write = 1'b0;
        step();
        chk("none_ign", {30'b0, in_ready, mem_req}, 32'd2);

        // Held in_valid while busy; gnt low for 5 cycles
        mem_read = 1'b1; addr = 32'h500;
        step();
        addr = 32'h600;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {31'b0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, 32'h500);
            chk("stall_ready", {31'b0, in_ready}, 32'd0);
            step();
        end
        beat("stall", 32'h500, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h01020304, 1'b0);
        chk("b2b_done_busy", {30'b0, resp_valid, in_ready}, 32'd2);
        chk("b2b_rdata", rdata, 32'h01020304);
        step();
        chk("b2b_idle", {30'b0, in_ready, mem_req}, 32'd2);
        step();
        in_valid = 1'b0;
        beat("b2b", 32'h600, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0A0B0C0D, 1'b0);
        done_chk("b2b", 32'h0A0B0C0D, 1'b0);

        // Reset in WAIT0 abandons the access; late rvalid ignored
        accept(1'b1, 1'b0, MEM_WORD, 32'h400, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_idle", {30'b0, in_ready, mem_req}, 32'd2);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        chk("late_rv_noresp", {30'b0, resp_valid, in_ready}, 32'd1);
        chk("late_rv_rdata", rdata, 32'h0);
        step();
        chk("late_rv_noresp2", {30'b0, resp_valid, mem_req}, 32'd0);

        // MISALIGN_SPLIT=0: error response, no bus access
        in_valid_b = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_op = MEM_WORD; addr = 32'h101;
        step();
        in_valid_b = 1'b0;
        chk("ns_resp", {30'b0, resp_valid_b, mis_b}, 32'd3);
        chk("ns_noreq", {30'b0, req_b, fault_b}, 32'd0);
        chk("ns_rdata", rdata_b, 32'h0);
        step();
        chk("ns_after", {29'b0, resp_valid_b, mis_b, in_ready_b}, 32'd3);
        chk("ns_noreq2", {31'b0, req_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
